// File: rtl/gnrl_pipe_dfflr_pkg.sv
// ---------------------------------------------------------------------------
// gnrl_pipe_dfflr_pkg
// Shared helpers for the general pipeline register family:
//   pipe_clog2     - ceil(log2(n)) with a floor of 1, used to size count
//   pipe_depth_ok  - elaboration-time legality check for DEPTH
// ---------------------------------------------------------------------------
package gnrl_pipe_dfflr_pkg;

  // Returns the number of bits needed to hold the values 0..n-1.
  // A minimum of 1 bit is always returned.
  function automatic int pipe_clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // A pipeline with no stages has no output register to drive o_data.
  function automatic bit pipe_depth_ok(input int depth);
    return depth >= 1;
  endfunction

endpackage

// File: rtl/gnrl_pipe_dfflr_if.sv
// ---------------------------------------------------------------------------
// gnrl_pipe_dfflr_if
// Valid/ready handshake bundle for the pipeline register.
//   i_valid/i_ready/i_data : upstream side (producer -> pipe)
//   o_valid/o_ready/o_data : downstream side (pipe -> consumer)
// Modports:
//   master - the environment around the pipe (drives i_valid/i_data/o_ready)
//   slave  - the pipe itself (drives i_ready/o_valid/o_data)
// ---------------------------------------------------------------------------
interface gnrl_pipe_dfflr_if #(
  parameter int DW = 32
);
  logic          i_valid;
  logic          i_ready;
  logic [DW-1:0] i_data;
  logic          o_valid;
  logic          o_ready;
  logic [DW-1:0] o_data;

  modport master (
    output i_valid,
    output i_data,
    output o_ready,
    input  i_ready,
    input  o_valid,
    input  o_data
  );

  modport slave (
    input  i_valid,
    input  i_data,
    input  o_ready,
    output i_ready,
    output o_valid,
    output o_data
  );
endinterface

// File: rtl/gnrl_pipe_dfflr_stage.sv
// ---------------------------------------------------------------------------
// gnrl_pipe_dfflr_stage
// One pipeline stage: a valid flop plus a DW-bit data register with load
// enable. The data register is a dfflr (async reset to RST_VAL) when
// DATA_RST=1, or a plain dffl (no reset) when DATA_RST=0.
// Ports:
//   clk, rst_n : clock and async active-low reset
//   i_flush    : synchronous clear of the valid flop
//   i_adv      : this stage may take a new value this cycle
//   i_vld      : valid of the value offered to this stage
//   i_dat      : data offered to this stage
//   o_vld      : stage valid
//   o_dat      : stage data
// ---------------------------------------------------------------------------
module gnrl_pipe_dfflr_stage #(
  parameter int          DW       = 32,
  parameter bit          DATA_RST = 1'b1,
  parameter logic [DW-1:0] RST_VAL = {DW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_adv,
  input  logic          i_vld,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  output logic [DW-1:0] o_dat
);

  logic          r_vld;
  logic [DW-1:0] r_dat;
  logic          w_dat_en;

  // Data only moves when a valid item actually lands here; bubbles do not
  // disturb the data register. Flush leaves data untouched.
  assign w_dat_en = i_adv & i_vld & ~i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= 1'b0;
    end else if (i_flush) begin
      r_vld <= 1'b0;
    end else if (i_adv) begin
      r_vld <= i_vld;
    end
  end

  generate
    if (DATA_RST) begin : g_dfflr
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_dat <= RST_VAL;
        end else if (w_dat_en) begin
          r_dat <= i_dat;
        end
      end
    end else begin : g_dffl
      always_ff @(posedge clk) begin
        if (w_dat_en) begin
          r_dat <= i_dat;
        end
      end
    end
  endgenerate

  assign o_vld = r_vld;
  assign o_dat = r_dat;

endmodule

// File: rtl/gnrl_pipe_dfflr.sv
// ---------------------------------------------------------------------------
// gnrl_pipe_dfflr
// DEPTH-stage pipeline register with valid/ready flow control, bubble
// collapsing, synchronous flush and an occupancy counter.
// Stage 0 is the input side; stage DEPTH-1 drives o_valid/o_data.
// Ports:
//   clk, rst_n : clock and async active-low reset
//   flush      : synchronous clear of every stage valid (and count)
//   bus        : handshake bundle (slave view), see gnrl_pipe_dfflr_if
//   count      : registered number of valid stages, 0..DEPTH
// ---------------------------------------------------------------------------
module gnrl_pipe_dfflr
  import gnrl_pipe_dfflr_pkg::*;
#(
  parameter int            DW       = 32,
  parameter int            DEPTH    = 2,
  parameter bit            DATA_RST = 1'b1,
  parameter logic [DW-1:0] RST_VAL  = {DW{1'b0}},
  localparam int           CW       = pipe_clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  gnrl_pipe_dfflr_if.slave      bus,
  output logic [CW-1:0]         count
);

  generate
    if (!pipe_depth_ok(DEPTH)) begin : g_depth_err
      $error("gnrl_pipe_dfflr: DEPTH must be >= 1");
    end
  endgenerate

  logic [DEPTH-1:0] w_vld;
  logic [DEPTH-1:0] w_adv;
  logic [DW-1:0]    w_dat [DEPTH];
  logic             w_full_tail;
  logic             w_in_fire;
  logic             w_out_fire;
  logic [CW-1:0]    r_count;

  // Advance chain, unrolled: stage k may advance if o_ready is high or any
  // stage from k to the output is empty. Walking from the output end with a
  // running AND keeps w_adv free of bit-to-bit feedback.
  always_comb begin
    w_adv       = '0;
    w_full_tail = 1'b1;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      w_full_tail = w_full_tail & w_vld[k];
      w_adv[k]    = bus.o_ready | ~w_full_tail;
    end
  end

  genvar gk;
  generate
    for (gk = 0; gk < DEPTH; gk++) begin : g_stage
      logic          w_stg_vld;
      logic [DW-1:0] w_stg_dat;

      if (gk == 0) begin : g_head
        assign w_stg_vld = bus.i_valid;
        assign w_stg_dat = bus.i_data;
      end else begin : g_body
        assign w_stg_vld = w_vld[gk-1];
        assign w_stg_dat = w_dat[gk-1];
      end

      gnrl_pipe_dfflr_stage #(
        .DW       (DW),
        .DATA_RST (DATA_RST),
        .RST_VAL  (RST_VAL)
      ) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (flush),
        .i_adv   (w_adv[gk]),
        .i_vld   (w_stg_vld),
        .i_dat   (w_stg_dat),
        .o_vld   (w_vld[gk]),
        .o_dat   (w_dat[gk])
      );
    end
  endgenerate

  assign w_in_fire  = bus.i_valid & w_adv[0];
  assign w_out_fire = w_vld[DEPTH-1] & bus.o_ready;

  // Occupancy tracks popcount(vld). Flush wins: anything accepted in the
  // flush cycle is dropped, and a pop in that cycle was already delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      case ({w_in_fire, w_out_fire})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.i_ready = w_adv[0];
  assign bus.o_valid = w_vld[DEPTH-1];
  assign bus.o_data  = w_dat[DEPTH-1];
  assign count       = r_count;

endmodule

// File: tb/tb_gnrl_pipe_dfflr.sv
// ---------------------------------------------------------------------------
// tb_gnrl_pipe_dfflr
// Bench for gnrl_pipe_dfflr with DW=8, DEPTH=3, RST_VAL=8'hA5.
// Two instances share all stimulus: u_dut (DATA_RST=1) and u_dut_nr
// (DATA_RST=0). The no-reset instance is held to the same handshake and
// data expectations, with o_data ignored while o_valid=0.
// ---------------------------------------------------------------------------
module tb_gnrl_pipe_dfflr;

  localparam int            DW      = 8;
  localparam int            DEPTH   = 3;
  localparam logic [DW-1:0] RST_VAL = 8'hA5;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [1:0] count;
  logic [1:0] count_nr;

  gnrl_pipe_dfflr_if #(.DW(DW)) bus    ();
  gnrl_pipe_dfflr_if #(.DW(DW)) bus_nr ();

  gnrl_pipe_dfflr #(
    .DW(DW), .DEPTH(DEPTH), .DATA_RST(1'b1), .RST_VAL(RST_VAL)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus), .count(count)
  );

  gnrl_pipe_dfflr #(
    .DW(DW), .DEPTH(DEPTH), .DATA_RST(1'b0), .RST_VAL(RST_VAL)
  ) u_dut_nr (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_nr), .count(count_nr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
    bus.i_valid    = iv;
    bus.i_data     = id;
    bus.o_ready    = ordy;
    bus_nr.i_valid = iv;
    bus_nr.i_data  = id;
    bus_nr.o_ready = ordy;
    flush          = fl;
  endtask

  // Inputs applied for one cycle and the outputs expected during that cycle
  // (before the closing clock edge).
  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       fl;
    logic       e_ov;
    logic [7:0] e_od;
    int         e_cnt;
    logic       e_ir;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic iv, input logic [7:0] id, input logic ordy,
                              input logic fl, input logic e_ov, input logic [7:0] e_od,
                              input int e_cnt, input logic e_ir);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
    v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt; v.e_ir = e_ir;
    vecs.push_back(v);
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, ".o_valid"},    32'(bus.o_valid),    32'd0);
    chk({tag, ".o_data"},     32'(bus.o_data),     32'(RST_VAL));
    chk({tag, ".count"},      32'(count),          32'd0);
    chk({tag, ".i_ready"},    32'(bus.i_ready),    32'd1);
    chk({tag, ".nr.o_valid"}, 32'(bus_nr.o_valid), 32'd0);
    chk({tag, ".nr.count"},   32'(count_nr),       32'd0);
    chk({tag, ".nr.i_ready"}, 32'(bus_nr.i_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] next_item;
    logic [7:0] exp_d;
    int         n_out;
    int         budget;

    // streaming 01..05, o_ready=1
    add(1, 8'h01, 1, 0,  0, 8'h00, 0, 1);
    add(1, 8'h02, 1, 0,  0, 8'h00, 1, 1);
    add(1, 8'h03, 1, 0,  0, 8'h00, 2, 1);
    add(1, 8'h04, 1, 0,  1, 8'h01, 3, 1);
    add(1, 8'h05, 1, 0,  1, 8'h02, 3, 1);
    add(0, 8'h00, 1, 0,  1, 8'h03, 3, 1);
    add(0, 8'h00, 1, 0,  1, 8'h04, 2, 1);
    add(0, 8'h00, 1, 0,  1, 8'h05, 1, 1);
    add(0, 8'h00, 1, 0,  0, 8'h00, 0, 1);
    // back-pressure 10..13
    add(1, 8'h10, 0, 0,  0, 8'h00, 0, 1);
    add(1, 8'h11, 0, 0,  0, 8'h00, 1, 1);
    add(1, 8'h12, 0, 0,  0, 8'h00, 2, 1);
    add(1, 8'h13, 0, 0,  1, 8'h10, 3, 0);
    add(1, 8'h13, 1, 0,  1, 8'h10, 3, 1);
    add(0, 8'h00, 1, 0,  1, 8'h11, 3, 1);
    add(0, 8'h00, 1, 0,  1, 8'h12, 2, 1);
    add(0, 8'h00, 1, 0,  1, 8'h13, 1, 1);
    add(0, 8'h00, 1, 0,  0, 8'h00, 0, 1);
    // bubble collapse with o_ready=0
    add(1, 8'h11, 0, 0,  0, 8'h00, 0, 1);
    add(0, 8'h00, 0, 0,  0, 8'h00, 1, 1);
    add(0, 8'h00, 0, 0,  0, 8'h00, 1, 1);
    add(1, 8'h22, 0, 0,  1, 8'h11, 1, 1);
    add(0, 8'h00, 0, 0,  1, 8'h11, 2, 1);
    add(1, 8'h33, 0, 0,  1, 8'h11, 2, 1);
    add(0, 8'h00, 0, 0,  1, 8'h11, 3, 0);
    // flush while full and stalled, 0x44 offered
    add(1, 8'h44, 0, 1,  1, 8'h11, 3, 0);
    add(0, 8'h00, 0, 0,  0, 8'h00, 0, 1);
    // flush in a cycle where 0x44 is actually accepted
    add(1, 8'h55, 1, 0,  0, 8'h00, 0, 1);
    add(1, 8'h44, 1, 1,  0, 8'h00, 1, 1);
    add(0, 8'h00, 1, 0,  0, 8'h00, 0, 1);
    add(0, 8'h00, 1, 0,  0, 8'h00, 0, 1);
    add(0, 8'h00, 1, 0,  0, 8'h00, 0, 1);

    // reset asserted between clock edges must act immediately
    rst_n = 1'b1;
    drive(0, 8'h00, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].fl);
      #1;
      chk($sformatf("row%0d.o_valid", i), 32'(bus.o_valid), 32'(vecs[i].e_ov));
      chk($sformatf("row%0d.count", i),   32'(count),       32'(vecs[i].e_cnt));
      chk($sformatf("row%0d.i_ready", i), 32'(bus.i_ready), 32'(vecs[i].e_ir));
      if (vecs[i].e_ov)
        chk($sformatf("row%0d.o_data", i), 32'(bus.o_data), 32'(vecs[i].e_od));
      chk($sformatf("row%0d.nr.o_valid", i), 32'(bus_nr.o_valid), 32'(vecs[i].e_ov));
      chk($sformatf("row%0d.nr.count", i),   32'(count_nr),       32'(vecs[i].e_cnt));
      chk($sformatf("row%0d.nr.i_ready", i), 32'(bus_nr.i_ready), 32'(vecs[i].e_ir));
      if (vecs[i].e_ov)
        chk($sformatf("row%0d.nr.o_data", i), 32'(bus_nr.o_data), 32'(vecs[i].e_od));
      @(posedge clk);
      #1;
    end

    // random handshake traffic against a FIFO model: ordering, occupancy
    // and i_ready = not full or o_ready
    next_item = 8'h60;
    n_out     = 0;
    budget    = 400;
    while (n_out < 32 && budget > 0) begin
      drive((next_item < 8'h80) ? 1'($urandom_range(0, 1)) : 1'b0, next_item,
            1'($urandom_range(0, 1)), 1'b0);
      #1;
      chk("rnd.count", 32'(count), 32'(q.size()));
      chk("rnd.i_ready", 32'(bus.i_ready),
          32'((q.size() < DEPTH) || bus.o_ready));
      if (bus.o_valid && bus.o_ready) begin
        exp_d = (q.size() > 0) ? q.pop_front() : 8'hXX;
        chk("rnd.o_data", 32'(bus.o_data), 32'(exp_d));
        n_out++;
      end
      if (bus.i_valid && bus.i_ready) begin
        q.push_back(next_item);
        next_item = next_item + 8'h01;
      end
      @(posedge clk);
      #1;
      budget--;
    end
    chk("rnd.delivered", 32'(n_out), 32'd32);

    // fill the pipe, then drop reset mid-cycle
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 8'h70 + 8'(i), 0, 0);
      @(posedge clk);
      #1;
    end
    drive(0, 8'h00, 0, 0);
    #1;
    chk("full.count", 32'(count), 32'(DEPTH));
    chk("full.o_data", 32'(bus.o_data), 32'h70);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_state("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst.o_valid", 32'(bus.o_valid), 32'd0);
    chk("postrst.count",   32'(count),       32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
